// File: rtl/unified_mem_arbiter_if.sv
// Bundle of fetch, data, stall and unified-memory signals shared by the arbiter and its neighbours.
// The arbiter takes the slave view; the pipeline/memory environment takes the master view.
interface unified_mem_arbiter_if #(
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64,
    parameter int INSTR_W = 32
);
    logic               if_req;
    logic [ADDR_W-1:0]  if_addr;
    logic               if_flush;
    logic               if_valid;
    logic [INSTR_W-1:0] if_instr;

    logic               d_req;
    logic               d_we;
    logic [ADDR_W-1:0]  d_addr;
    logic [DATA_W-1:0]  d_wdata;
    logic               d_valid;
    logic [DATA_W-1:0]  d_rdata;

    logic               stall_if;
    logic               stall_mem;

    logic               mem_req;
    logic               mem_we;
    logic [ADDR_W-1:0]  mem_addr;
    logic [DATA_W-1:0]  mem_wdata;
    logic [DATA_W-1:0]  mem_rdata;
    logic               mem_ready;

    modport slave (
        input  if_req, if_addr, if_flush, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
        output if_valid, if_instr, d_valid, d_rdata, stall_if, stall_mem,
               mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr, if_flush, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
        input  if_valid, if_instr, d_valid, d_rdata, stall_if, stall_mem,
               mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Shares one variable-latency single-port memory between instruction fetch and the MEM stage,
// with a bounded data streak so fetches cannot starve, and flush-cancellation of fetches.
module unified_mem_arbiter #(
    parameter int ADDR_W          = 64,
    parameter int DATA_W          = 64,
    parameter int INSTR_W         = 32,
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic                clk,
    input  logic                rst,
    unified_mem_arbiter_if.slave bus
);
    localparam int STREAK_W = $clog2(MAX_DATA_STREAK + 1);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DATA
    } state_t;

    state_t               state, state_next;
    logic [STREAK_W-1:0]  streak, streak_next;
    logic                 cancel, cancel_next;
    logic                 if_valid_reg, if_valid_next;
    logic                 d_valid_reg, d_valid_next;
    logic                 mem_we_reg, mem_we_next;
    logic [ADDR_W-1:0]    mem_addr_reg, mem_addr_next;
    logic [DATA_W-1:0]    mem_wdata_reg, mem_wdata_next;
    logic [DATA_W-1:0]    d_rdata_reg, d_rdata_next;
    logic [INSTR_W-1:0]   if_instr_reg, if_instr_next;

    logic if_valid_out;
    logic complete;
    logic arbitrate;
    logic fetch_eligible;
    logic data_eligible;
    logic streak_full;
    logic grant_data;
    logic grant_fetch;
    logic fetch_dropped;

    // A requester still seeing its valid pulse has not released the request yet, so it is not re-granted.
    assign if_valid_out   = if_valid_reg & ~bus.if_flush;
    assign complete       = (state != IDLE) & bus.mem_ready;
    assign arbitrate      = (state == IDLE) | complete;
    assign fetch_eligible = bus.if_req & ~if_valid_out;
    assign data_eligible  = bus.d_req & ~d_valid_reg;
    assign streak_full    = (streak == STREAK_W'(MAX_DATA_STREAK));
    assign grant_data     = arbitrate & data_eligible & ~(fetch_eligible & streak_full);
    assign grant_fetch    = arbitrate & fetch_eligible & ~grant_data;
    assign fetch_dropped  = cancel | bus.if_flush;

    always_comb begin
        state_next     = state;
        streak_next    = streak;
        cancel_next    = cancel;
        if_valid_next  = 1'b0;
        d_valid_next   = 1'b0;
        mem_we_next    = mem_we_reg;
        mem_addr_next  = mem_addr_reg;
        mem_wdata_next = mem_wdata_reg;
        d_rdata_next   = d_rdata_reg;
        if_instr_next  = if_instr_reg;

        if (state == FETCH && bus.if_flush) begin
            cancel_next = 1'b1;
        end

        if (complete) begin
            if (state == FETCH) begin
                cancel_next = 1'b0;
                if (!fetch_dropped) begin
                    if_instr_next = bus.mem_rdata[INSTR_W-1:0];
                    if_valid_next = 1'b1;
                end
            end else begin
                d_valid_next = 1'b1;
                if (!mem_we_reg) begin
                    d_rdata_next = bus.mem_rdata;
                end
            end
        end

        if (arbitrate) begin
            if (grant_data) begin
                state_next     = DATA;
                mem_we_next    = bus.d_we;
                mem_addr_next  = bus.d_addr;
                mem_wdata_next = bus.d_wdata;
            end else if (grant_fetch) begin
                state_next    = FETCH;
                mem_we_next   = 1'b0;
                mem_addr_next = bus.if_addr;
            end else begin
                state_next  = IDLE;
                mem_we_next = 1'b0;
            end
        end

        if (!bus.if_req || grant_fetch) begin
            streak_next = '0;
        end else if (grant_data && !streak_full) begin
            streak_next = streak + STREAK_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            streak        <= '0;
            cancel        <= 1'b0;
            if_valid_reg  <= 1'b0;
            d_valid_reg   <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            d_rdata_reg   <= '0;
            if_instr_reg  <= '0;
        end else begin
            state         <= state_next;
            streak        <= streak_next;
            cancel        <= cancel_next;
            if_valid_reg  <= if_valid_next;
            d_valid_reg   <= d_valid_next;
            mem_we_reg    <= mem_we_next;
            mem_addr_reg  <= mem_addr_next;
            mem_wdata_reg <= mem_wdata_next;
            d_rdata_reg   <= d_rdata_next;
            if_instr_reg  <= if_instr_next;
        end
    end

    assign bus.mem_req   = (state != IDLE);
    assign bus.mem_we    = mem_we_reg & (state == DATA);
    assign bus.mem_addr  = mem_addr_reg;
    assign bus.mem_wdata = mem_wdata_reg;
    assign bus.if_valid  = if_valid_out;
    assign bus.if_instr  = if_instr_reg;
    assign bus.d_valid   = d_valid_reg;
    assign bus.d_rdata   = d_rdata_reg;
    assign bus.stall_mem = bus.d_req & ~d_valid_reg;
    assign bus.stall_if  = (bus.if_req & ~if_valid_out) | (bus.d_req & ~d_valid_reg);
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed scoreboard bench for unified_mem_arbiter driving a variable-latency memory model.
module tb_unified_mem_arbiter;
    localparam int ADDR_W          = 64;
    localparam int DATA_W          = 64;
    localparam int INSTR_W         = 32;
    localparam int MAX_DATA_STREAK = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int checks = 0;
    int errors = 0;
    int mem_wait = 0;
    int wait_cnt = 0;
    bit txn_start = 1'b1;

    logic [31:0] exp_if[$];
    logic [63:0] exp_d[$];
    logic [63:0] grant_log[$];
    logic [63:0] exp_grants[6];
    logic [31:0] last_instr = '0;
    logic [63:0] last_d = '0;

    unified_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .INSTR_W(INSTR_W)) bus ();

    unified_mem_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .INSTR_W(INSTR_W), .MAX_DATA_STREAK(MAX_DATA_STREAK)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Memory contents: a few fixed words, everything else derived from the address.
    function automatic logic [63:0] mem_model(input logic [63:0] addr);
        case (addr)
            64'h40:  return 64'hFFFF_FFFF_0050_0093;
            64'h100: return 64'h0000_0000_0000_DEAD;
            default: return {addr[31:0] ^ 32'h5A5A_5A5A, addr[31:0] + 32'h13};
        endcase
    endfunction

    function automatic logic [31:0] instr_model(input logic [63:0] addr);
        logic [63:0] w;
        w = mem_model(addr);
        return w[31:0];
    endfunction

    always @(posedge clk) begin
        if (rst || !bus.mem_req || bus.mem_ready) wait_cnt <= 0;
        else                                      wait_cnt <= wait_cnt + 1;
    end

    assign bus.mem_ready = bus.mem_req && (wait_cnt == mem_wait);
    assign bus.mem_rdata = mem_model(bus.mem_addr);

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input bit f_req, input logic [63:0] f_addr,
                                  input bit dreq, input bit we, input logic [63:0] daddr,
                                  input logic [63:0] wdata);
        bus.if_req  = f_req;
        bus.if_addr = f_addr;
        bus.d_req   = dreq;
        bus.d_we    = we;
        bus.d_addr  = daddr;
        bus.d_wdata = wdata;
    endtask

    // Waits for the completing cycle of the current transaction, then releases both requests.
    task automatic wait_complete(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = bus.mem_ready;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("[TB] FAIL %s: got no mem_ready, expected completion within 20 cycles", name);
        end
        #1;
        bus.if_req = 1'b0;
        bus.d_req  = 1'b0;
    endtask

    // Scoreboard monitor: stall equations every cycle, responses popped on each valid pulse.
    always @(negedge clk) begin
        check_output("stall_mem", bus.stall_mem, bus.d_req & ~bus.d_valid);
        check_output("stall_if", bus.stall_if, (bus.if_req & ~bus.if_valid) | (bus.d_req & ~bus.d_valid));
        if (bus.if_valid) begin
            if (exp_if.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL if_valid: got pulse with instr 0x%0h, expected none", bus.if_instr);
            end else begin
                check_output("if_instr", bus.if_instr, exp_if.pop_front());
            end
        end
        if (bus.d_valid) begin
            if (exp_d.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL d_valid: got pulse with rdata 0x%0h, expected none", bus.d_rdata);
            end else begin
                check_output("d_rdata", bus.d_rdata, exp_d.pop_front());
            end
        end
        if (bus.mem_req && txn_start) grant_log.push_back(bus.mem_addr);
        txn_start = !bus.mem_req || bus.mem_ready;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got no end of test, expected finish before 100us");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.if_flush = 1'b0;
        apply_stimulus(0, 0, 0, 0, 0, 0);
        exp_grants = '{64'h500, 64'h500, 64'h300, 64'h500, 64'h500, 64'h300};

        // Reset state
        @(posedge clk);
        @(negedge clk);
        check_output("reset mem_req", bus.mem_req, 0);
        check_output("reset mem_we", bus.mem_we, 0);
        check_output("reset mem_addr", bus.mem_addr, 0);
        check_output("reset mem_wdata", bus.mem_wdata, 0);
        check_output("reset if_valid", bus.if_valid, 0);
        check_output("reset d_valid", bus.d_valid, 0);
        check_output("reset if_instr", bus.if_instr, 0);
        check_output("reset d_rdata", bus.d_rdata, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);

        // Zero-wait fetch
        #1;
        apply_stimulus(1, 64'h40, 0, 0, 0, 0);
        exp_if.push_back(instr_model(64'h40));
        @(negedge clk);
        check_output("t1 mem_req c0", bus.mem_req, 0);
        check_output("t1 stall_if c0", bus.stall_if, 1);
        @(negedge clk);
        check_output("t1 mem_req c1", bus.mem_req, 1);
        check_output("t1 mem_addr c1", bus.mem_addr, 64'h40);
        check_output("t1 stall_if c1", bus.stall_if, 1);
        #1 bus.if_req = 1'b0;
        @(negedge clk);
        check_output("t1 if_valid c2", bus.if_valid, 1);
        check_output("t1 stall_if c2", bus.stall_if, 0);
        last_instr = instr_model(64'h40);
        repeat (2) @(posedge clk);

        // Simultaneous fetch and load: data first, fetch back-to-back
        #1;
        apply_stimulus(1, 64'h44, 1, 0, 64'h100, 0);
        exp_d.push_back(mem_model(64'h100));
        exp_if.push_back(instr_model(64'h44));
        @(negedge clk);
        check_output("t2 stall_mem c0", bus.stall_mem, 1);
        @(negedge clk);
        check_output("t2 mem_addr c1", bus.mem_addr, 64'h100);
        check_output("t2 mem_we c1", bus.mem_we, 0);
        #1 bus.d_req = 1'b0;
        @(negedge clk);
        check_output("t2 d_valid c2", bus.d_valid, 1);
        check_output("t2 mem_req c2", bus.mem_req, 1);
        check_output("t2 fetch addr c2", bus.mem_addr, 64'h44);
        check_output("t2 stall_if c2", bus.stall_if, 1);
        #1 bus.if_req = 1'b0;
        @(negedge clk);
        check_output("t2 if_valid c3", bus.if_valid, 1);
        last_d = mem_model(64'h100);
        last_instr = instr_model(64'h44);
        repeat (2) @(posedge clk);

        // Starvation bound with one wait cycle per transaction
        mem_wait = 1;
        grant_log.delete();
        #1;
        apply_stimulus(1, 64'h300, 1, 0, 64'h500, 0);
        for (int i = 0; i < 4; i++) exp_d.push_back(mem_model(64'h500));
        for (int i = 0; i < 2; i++) exp_if.push_back(instr_model(64'h300));
        for (int i = 0; i < 40 && grant_log.size() < 6; i++) @(negedge clk);
        #1;
        bus.if_req = 1'b0;
        bus.d_req  = 1'b0;
        repeat (4) @(negedge clk);
        check_output("t3 grant count", grant_log.size(), 6);
        for (int i = 0; i < 6; i++) begin
            if (i < grant_log.size()) check_output($sformatf("t3 grant %0d", i), grant_log[i], exp_grants[i]);
        end
        last_d = mem_model(64'h500);
        last_instr = instr_model(64'h300);
        repeat (2) @(posedge clk);

        // Flush during a 3-wait-cycle fetch, redirect to 0x80
        mem_wait = 3;
        #1;
        apply_stimulus(1, 64'h60, 0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        check_output("t4 mem_addr c1", bus.mem_addr, 64'h60);
        @(posedge clk); #1;
        bus.if_flush = 1'b1;
        bus.if_addr  = 64'h80;
        @(posedge clk); #1;
        bus.if_flush = 1'b0;
        exp_if.push_back(instr_model(64'h80));
        begin
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 10 && !seen; i++) begin
                @(negedge clk);
                seen = bus.mem_ready;
            end
            check_output("t4 cancelled fetch completes", seen, 1);
        end
        @(negedge clk);
        check_output("t4 if_valid dropped", bus.if_valid, 0);
        check_output("t4 if_instr unchanged", bus.if_instr, last_instr);
        check_output("t4 next mem_req", bus.mem_req, 1);
        check_output("t4 next mem_addr", bus.mem_addr, 64'h80);
        wait_complete("t4 fetch 0x80");
        repeat (2) @(negedge clk);
        last_instr = instr_model(64'h80);

        // Flush coinciding with the valid cycle hides the pulse
        mem_wait = 0;
        @(posedge clk); #1;
        apply_stimulus(1, 64'h84, 0, 0, 0, 0);
        wait_complete("t4b fetch 0x84");
        @(posedge clk); #1;
        bus.if_flush = 1'b1;
        @(negedge clk);
        check_output("t4b if_valid flushed", bus.if_valid, 0);
        check_output("t4b if_instr loaded", bus.if_instr, instr_model(64'h84));
        @(posedge clk); #1;
        bus.if_flush = 1'b0;
        @(negedge clk);
        check_output("t4b if_valid after", bus.if_valid, 0);
        last_instr = instr_model(64'h84);

        // Store held stable across two wait cycles while requester inputs change
        mem_wait = 2;
        @(posedge clk); #1;
        apply_stimulus(0, 0, 1, 1, 64'h200, 64'h1234);
        exp_d.push_back(last_d);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_output($sformatf("t5 mem_req %0d", i), bus.mem_req, 1);
            check_output($sformatf("t5 mem_we %0d", i), bus.mem_we, 1);
            check_output($sformatf("t5 mem_addr %0d", i), bus.mem_addr, 64'h200);
            check_output($sformatf("t5 mem_wdata %0d", i), bus.mem_wdata, 64'h1234);
            if (i == 0) begin
                #1;
                bus.d_addr  = 64'h999;
                bus.d_wdata = 64'hFFFF;
                bus.d_we    = 1'b0;
            end
            if (i == 2) begin
                #1 bus.d_req = 1'b0;
            end
        end
        @(negedge clk);
        check_output("t5 d_valid", bus.d_valid, 1);
        check_output("t5 mem_we idle", bus.mem_we, 0);
        repeat (2) @(posedge clk);

        // Reset in a DATA wait cycle abandons the transaction
        mem_wait = 3;
        #1;
        apply_stimulus(0, 0, 1, 0, 64'h300, 0);
        @(negedge clk);
        @(negedge clk);
        check_output("t6 mem_req c1", bus.mem_req, 1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_output("t6 mem_req", bus.mem_req, 0);
        check_output("t6 mem_we", bus.mem_we, 0);
        check_output("t6 mem_addr", bus.mem_addr, 0);
        check_output("t6 mem_wdata", bus.mem_wdata, 0);
        check_output("t6 if_instr", bus.if_instr, 0);
        check_output("t6 d_rdata", bus.d_rdata, 0);
        check_output("t6 d_valid", bus.d_valid, 0);
        check_output("t6 if_valid", bus.if_valid, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        bus.d_req = 1'b0;
        repeat (4) @(negedge clk);

        check_output("exp_if drained", exp_if.size(), 0);
        check_output("exp_d drained", exp_d.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
